// File: rtl/bp_pkg.sv
// bp_pkg: shared constants for the branch predictor (counter encodings, default index width, PC step).
// Rev 1.0
`default_nettype none

package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  localparam int unsigned IDXW_DEF = 4;
  localparam logic [31:0] PC_INC   = 32'd4;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: IF/ID-side signal bundle between the pipeline (master) and the predictor (slave).
// Rev 1.0
`default_nettype none

interface branch_predictor_if;
  logic [31:0] ifpc;
  logic        stall;
  logic        idvalid;
  logic        idisbranch;
  logic        idtaken;
  logic [31:0] idtarget;
  logic        predtaken;
  logic [31:0] predtarget;
  logic        mispredict;
  logic [31:0] redirectpc;
  logic [31:0] branchcount;
  logic [31:0] mispredcount;

  modport master (
    output ifpc, stall, idvalid, idisbranch, idtaken, idtarget,
    input  predtaken, predtarget, mispredict, redirectpc, branchcount, mispredcount
  );

  modport slave (
    input  ifpc, stall, idvalid, idisbranch, idtaken, idtarget,
    output predtaken, predtarget, mispredict, redirectpc, branchcount, mispredcount
  );
endinterface

`default_nettype wire

// File: rtl/sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating branch counter.
// Rev 1.0
`default_nettype none

module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = cnt;
    if (taken) begin
      if (cnt != ST) next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next = cnt - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, IF->ID prediction register and ID redirect.
// Optional statistics counters built only when BRANCH_PRED_STATS_EN is defined. Rev 1.0
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDXW    = IDXW_DEF,
  parameter logic [1:0]  INITCNT = WNT
) (
  input logic                clk,
  input logic                reset,
  branch_predictor_if.slave  bp
);

  localparam int unsigned NENT = 1 << IDXW;
  localparam int unsigned TAGW = 32 - IDXW - 2;

  logic [NENT-1:0] valid_q;
  logic [TAGW-1:0] tag_q    [NENT];
  logic [31:0]     target_q [NENT];
  logic [1:0]      cnt_q    [NENT];

  logic        pq_valid_q, pq_valid_d;
  logic        pq_taken_q, pq_taken_d;
  logic [31:0] pq_target_q, pq_target_d;
  logic [31:0] pq_pc_q, pq_pc_d;

  logic [IDXW-1:0] if_idx;
  logic            if_hit;
  logic [IDXW-1:0] up_idx;
  logic            up_hit;
  logic            pq_live;
  logic            mispred;
  logic [31:0]     redirect;
  logic            train_en;
  logic            inval_en;
  logic [1:0]      cnt_next;

  assign if_idx = bp.ifpc[IDXW+1:2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == bp.ifpc[31:IDXW+2]);

  assign bp.predtaken  = ~reset & if_hit & cnt_q[if_idx][1];
  assign bp.predtarget = bp.predtaken ? target_q[if_idx] : bp.ifpc + PC_INC;

  assign pq_live = ~reset & bp.idvalid & pq_valid_q;

  always_comb begin
    mispred  = 1'b0;
    redirect = '0;
    if (pq_live) begin
      if (bp.idisbranch) begin
        if (bp.idtaken != pq_taken_q) begin
          mispred  = 1'b1;
          redirect = bp.idtaken ? bp.idtarget : pq_pc_q + PC_INC;
        end else if (bp.idtaken && (bp.idtarget != pq_target_q)) begin
          mispred  = 1'b1;
          redirect = bp.idtarget;
        end
      end else if (pq_taken_q) begin
        mispred  = 1'b1;
        redirect = pq_pc_q + PC_INC;
      end
    end
  end

  assign bp.mispredict = mispred;
  assign bp.redirectpc = redirect;

  // Training looks the table up again with the ID-stage PC, so it sees writes made since the fetch.
  assign up_idx   = pq_pc_q[IDXW+1:2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == pq_pc_q[31:IDXW+2]);
  assign train_en = pq_live & ~bp.stall & bp.idisbranch;
  assign inval_en = mispred & ~bp.stall & ~bp.idisbranch;

  sat_counter2 u_sat (
    .cnt   (cnt_q[up_idx]),
    .taken (bp.idtaken),
    .next  (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (train_en) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_next;
        if (bp.idtaken) target_q[up_idx] <= bp.idtarget;
      end else if (bp.idtaken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= pq_pc_q[31:IDXW+2];
        target_q[up_idx] <= bp.idtarget;
        cnt_q[up_idx]    <= WT;
      end
    end else if (inval_en) begin
      valid_q[up_idx] <= 1'b0;
      cnt_q[up_idx]   <= INITCNT;
    end
  end

  // Stall takes priority so a pending redirect survives until the hazard clears.
  always_comb begin
    pq_valid_d  = pq_valid_q;
    pq_taken_d  = pq_taken_q;
    pq_target_d = pq_target_q;
    pq_pc_d     = pq_pc_q;
    if (!bp.stall) begin
      pq_valid_d  = ~mispred;
      pq_taken_d  = bp.predtaken;
      pq_target_d = bp.predtarget;
      pq_pc_d     = bp.ifpc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pq_valid_q  <= 1'b0;
      pq_taken_q  <= 1'b0;
      pq_target_q <= '0;
      pq_pc_q     <= '0;
    end else begin
      pq_valid_q  <= pq_valid_d;
      pq_taken_q  <= pq_taken_d;
      pq_target_q <= pq_target_d;
      pq_pc_q     <= pq_pc_d;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] branchcount_q, branchcount_d;
  logic [31:0] mispredcount_q, mispredcount_d;

  always_comb begin
    branchcount_d  = branchcount_q;
    mispredcount_d = mispredcount_q;
    if (train_en) branchcount_d = branchcount_q + 32'd1;
    if (mispred && !bp.stall) mispredcount_d = mispredcount_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branchcount_q  <= '0;
      mispredcount_q <= '0;
    end else begin
      branchcount_q  <= branchcount_d;
      mispredcount_q <= mispredcount_d;
    end
  end

  assign bp.branchcount  = branchcount_q;
  assign bp.mispredcount = mispredcount_q;
`else
  assign bp.branchcount  = '0;
  assign bp.mispredcount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plus randomized checks of branch_predictor against a table-level model.
// Rev 1.0
`default_nettype none

module tb_branch_predictor;

  localparam int IDXW = 4;
  localparam int NENT = 1 << IDXW;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  branch_predictor_if bus ();

  branch_predictor #(.IDXW(IDXW), .INITCNT(2'b01)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: table entries as plain integers, prediction slot, statistics.
  bit          m_valid  [NENT];
  logic [31:0] m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_cnt    [NENT];
  bit          m_pqv;
  bit          m_pqt;
  logic [31:0] m_pqtgt;
  logic [31:0] m_pqpc;
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  logic        obs_pt;
  logic [31:0] obs_ptgt;
  logic        obs_mp;
  logic [31:0] obs_rpc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic logic [31:0] tagof(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tagof(pc));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input bit r, input logic [31:0] pc, input bit st, input bit v,
                      input bit br, input bit tk, input logic [31:0] tgt);
    bit          e_pt, e_mp, live;
    logic [31:0] e_ptgt, e_rpc;
    int          u;
    @(negedge clk);
    reset          = r;
    bus.ifpc       = pc;
    bus.stall      = st;
    bus.idvalid    = v;
    bus.idisbranch = br;
    bus.idtaken    = tk;
    bus.idtarget   = tgt;
    #1;
    e_pt   = !r && m_hit(pc) && (m_cnt[slot(pc)] >= 2);
    e_ptgt = e_pt ? m_target[slot(pc)] : pc + 32'd4;
    live   = !r && v && m_pqv;
    e_mp   = 1'b0;
    e_rpc  = 32'd0;
    if (live && br && (tk != m_pqt)) begin
      e_mp  = 1'b1;
      e_rpc = tk ? tgt : m_pqpc + 32'd4;
    end else if (live && br && tk && (tgt != m_pqtgt)) begin
      e_mp  = 1'b1;
      e_rpc = tgt;
    end else if (live && !br && m_pqt) begin
      e_mp  = 1'b1;
      e_rpc = m_pqpc + 32'd4;
    end
    obs_pt   = bus.predtaken;
    obs_ptgt = bus.predtarget;
    obs_mp   = bus.mispredict;
    obs_rpc  = bus.redirectpc;
    check_eq("predtaken", {31'd0, bus.predtaken}, {31'd0, e_pt});
    check_eq("predtarget", bus.predtarget, e_ptgt);
    check_eq("mispredict", {31'd0, bus.mispredict}, {31'd0, e_mp});
    check_eq("redirectpc", bus.redirectpc, e_rpc);
    if (!r) begin
`ifdef BRANCH_PRED_STATS_EN
      check_eq("branchcount", bus.branchcount, m_bc);
      check_eq("mispredcount", bus.mispredcount, m_mc);
`else
      check_eq("branchcount", bus.branchcount, 32'd0);
      check_eq("mispredcount", bus.mispredcount, 32'd0);
`endif
    end
    // Advance the model to the state after this edge.
    if (r) begin
      for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
      m_pqv = 1'b0;
      m_bc  = 32'd0;
      m_mc  = 32'd0;
    end else if (!st) begin
      u = slot(m_pqpc);
      if (live && br) begin
        m_bc = m_bc + 32'd1;
        if (m_hit(m_pqpc)) begin
          m_cnt[u] = tk ? ((m_cnt[u] == 3) ? 3 : m_cnt[u] + 1) : ((m_cnt[u] == 0) ? 0 : m_cnt[u] - 1);
          if (tk) m_target[u] = tgt;
        end else if (tk) begin
          m_valid[u]  = 1'b1;
          m_tag[u]    = tagof(m_pqpc);
          m_target[u] = tgt;
          m_cnt[u]    = 2;
        end
      end else if (e_mp) begin
        m_valid[u] = 1'b0;
        m_cnt[u]   = 1;
      end
      if (e_mp) m_mc = m_mc + 32'd1;
      m_pqv   = !e_mp;
      m_pqt   = e_pt;
      m_pqtgt = e_ptgt;
      m_pqpc  = pc;
    end
    @(posedge clk);
  endtask

  logic [31:0] pc_pool  [8];
  logic [31:0] tgt_pool [4];
  bit          outc     [5];
  bit          pexp     [5];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_bc = 0; m_mc = 0; m_pqv = 0; m_pqt = 0; m_pqtgt = 0; m_pqpc = 0;
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 0;
    end
    reset = 1'b1;
    bus.ifpc = 0; bus.stall = 0; bus.idvalid = 0; bus.idisbranch = 0; bus.idtaken = 0; bus.idtarget = 0;

    step(1, 32'h40, 0, 0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0, 0, 0);
    step(0, 32'h40, 0, 0, 0, 0, 0);
    check_eq("reset_pred", {31'd0, obs_pt}, 32'd0);
    check_eq("reset_ptgt", obs_ptgt, 32'h44);

    // Cold taken branch at 0x40 -> 0x80.
    step(0, 32'h44, 0, 1, 1, 1, 32'h80);
    check_eq("cold_mp", {31'd0, obs_mp}, 32'd1);
    check_eq("cold_redir", obs_rpc, 32'h80);
    step(0, 32'h80, 0, 0, 0, 0, 0);

    outc = '{1, 1, 0, 0, 0};
    pexp = '{1, 1, 1, 1, 0};
    for (int k = 0; k < 5; k++) begin
      step(0, 32'h40, 0, 0, 0, 0, 0);
      check_eq("seq_pred", {31'd0, obs_pt}, {31'd0, pexp[k]});
      if (k < 4) begin
        step(0, 32'h200, 0, 1, 1, outc[k], 32'h80);
        check_eq("seq_mp", {31'd0, obs_mp}, {31'd0, !outc[k]});
        if (k == 2) begin
          check_eq("nt_redir", obs_rpc, 32'h44);
          step(0, 32'h300, 0, 1, 1, 1, 32'h80);
          check_eq("pq_cleared", {31'd0, obs_mp}, 32'd0);
        end
      end
    end

    // Stalled taken branch (cnt now 01): redirect once stall drops.
    step(0, 32'h400, 1, 1, 1, 1, 32'h80);
    step(0, 32'h400, 1, 1, 1, 1, 32'h80);
    step(0, 32'h400, 0, 1, 1, 1, 32'h80);
    check_eq("stall_mp", {31'd0, obs_mp}, 32'd1);
    check_eq("stall_redir", obs_rpc, 32'h80);

    // Aliasing 0x40 / 0x440.
    step(0, 32'h440, 0, 0, 0, 0, 0);
    check_eq("alias_miss", {31'd0, obs_pt}, 32'd0);
    step(0, 32'h444, 0, 1, 1, 1, 32'h900);
    step(0, 32'h40, 0, 0, 0, 0, 0);
    check_eq("evicted", {31'd0, obs_pt}, 32'd0);
    step(0, 32'h440, 0, 0, 0, 0, 0);
    check_eq("alias_hit", obs_ptgt, 32'h900);
    // Predicted-taken non-branch: fall-through redirect and entry invalidated.
    step(0, 32'h900, 0, 1, 0, 0, 0);
    check_eq("nonbr_redir", obs_rpc, 32'h444);
    step(0, 32'h440, 0, 0, 0, 0, 0);
    check_eq("nonbr_inval", {31'd0, obs_pt}, 32'd0);

    pc_pool  = '{32'h40, 32'h44, 32'h440, 32'h80, 32'h1040, 32'h48, 32'h7ffc, 32'h100};
    tgt_pool = '{32'h80, 32'h900, 32'h2000, 32'h44};
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc, tg;
      pc = ($urandom_range(0, 7) == 7) ? ($urandom() & 32'hffff_fffc) : pc_pool[$urandom_range(0, 7)];
      tg = tgt_pool[$urandom_range(0, 3)];
      step($urandom_range(0, 79) == 0, pc, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, tg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and redirect unit for the 5-stage MIPS pipeline. It is the counterpart of the ID-stage branch resolver:
- In IF, it looks up the fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and supplies a predicted next PC.
- It carries that prediction alongside the IF/ID register.
- In ID, it compares the prediction with the resolved outcome, raises mispredict/flush with the corrected PC, and trains the table.

## Interface
Parameters:
- IDXW, 4, index width; table has 2^IDXW entries
- INITCNT, 2'b01, counter value written on allocation-miss clear (weakly not-taken)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- ifpc  input  32  PC being fetched this cycle
- stall  input  1  IF/ID hold (load-use hazard); freezes the internal IF→ID prediction register and blocks table updates
- idvalid  input  1  ID stage holds a real instruction (not a bubble)
- idisbranch  input  1  ID instruction is beq/bne (brancheq|branchneq)
- idtaken  input  1  resolved outcome from the branch select logic
- idtarget  input  32  resolved branch target
- predtaken  output  1  IF-stage prediction
- predtarget  output  32  IF-stage next PC: BTB target if predtaken, else ifpc+4
- mispredict  output  1  ID-stage correction required; also serves as the IF/ID flush
- redirectpc  output  32  corrected PC, valid when mispredict=1
- branchcount, mispredcount  output  32 each  statistics (see Configuration)

## Operation
- Entry fields: valid, tag = pc[31:IDXW+2], target[31:0], cnt[1:0].
- Index = pc[IDXW+1:2].
- Lookup (combinational): hit = valid & tag match; predtaken = hit & cnt[1].
- Prediction register (pq_valid, pq_taken, pq_target, pq_pc):
  - Loads {1, predtaken, predtarget, ifpc} each clock when stall=0.
  - Holds when stall=1.
  - Cleared (pq_valid=0) on the edge after mispredict=1.
- Mispredict conditions (evaluated only when idvalid & pq_valid):
  - idisbranch & (idtaken != pq_taken) → redirectpc = idtaken ? idtarget : pq_pc+4
  - idisbranch & idtaken & pq_taken & (idtarget != pq_target) → redirectpc = idtarget
  - ~idisbranch & pq_taken → redirectpc = pq_pc+4; the entry is invalidated
- Training (posedge, when idvalid & pq_valid & ~stall & idisbranch):
  - Hit: cnt saturating ±1 (toward 2'b11 if taken, toward 2'b00 if not); target ← idtarget when taken.
  - Miss and taken: allocate {valid=1, tag, idtarget, cnt=2'b10}.
  - Miss and not taken: no change.
- Same-index lookup and update in one cycle: lookup returns the pre-update contents (read-before-write).
- Reset clears all valid bits, pq_valid, and statistics. Reset outputs: predtaken=0, predtarget=ifpc+4, mispredict=0, redirectpc=0, counters=0.
- Reset asserted mid-operation discards any pending mispredict; no training occurs on the reset edge.

## Timing
- predtaken/predtarget: combinational from ifpc, same cycle.
- mispredict/redirectpc: combinational from the prediction register and ID inputs, same cycle as resolution. The PC loads redirectpc at the next edge, costing 1 bubble.
- Table write and statistics increment occur at the same edge as the PC redirect.
- A correct prediction costs 0 cycles; a misprediction costs 1 flushed IF slot.
- An entry trained at edge N is visible to lookups from cycle N+1 onward.

## Configuration
- BRANCH_PRED_STATS_EN defined:
  - branchcount increments per trained branch (idvalid & pq_valid & ~stall & idisbranch).
  - mispredcount increments per mispredict cycle with ~stall.
  - Both wrap at 2^32.
- Undefined: both outputs are tied to 0, and no counter registers are built.

## Structure
- Package bp_pkg:
  - Counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - Default IDXW
  - PC increment constant 4
- One sub-module, sat_counter2: 2-bit saturating next-value logic (inputs cnt, taken; output next). Instantiated in the update path.

## Test plan
- Reset then ifpc=0x40 → predtaken=0, predtarget=0x44; mispredict=0 for all cycles.
- Cold branch at 0x40, taken to 0x80 → mispredict=1, redirectpc=0x80; next fetch of 0x40 → predtaken=1, predtarget=0x80.
- Same branch resolved taken, taken, not-taken, not-taken → cnt 10→11→11→10→01; predictions T,T,T,T,NT; mispredict only on the two not-taken resolutions.
- Predicted-taken branch resolves not-taken at pq_pc=0x40 → redirectpc=0x44; pq_valid=0 next cycle.
- stall=1 for 2 cycles while the branch is in ID → no table change, prediction register held, redirect issued once stall drops.
- Aliasing PCs 0x40 and 0x440 (IDXW=4) → tag mismatch gives predtaken=0; allocating 0x440 evicts 0x40. With BRANCH_PRED_STATS_EN, branchcount and mispredcount match the scoreboard.
